// File: rtl/img_fb_pkg.sv
// Shared types and helpers for the image frame buffer AXI4 slave.
package img_fb_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WR_DATA = 2'b01,
    ST_WR_RESP = 2'b10,
    ST_RD_DATA = 2'b11
  } fsm_state_e;

  function automatic int idx_width(input int depth_words);
    return (depth_words > 1) ? $clog2(depth_words) : 1;
  endfunction

endpackage

// File: rtl/img_fb_burst_addr.sv
// Per-beat next-address, error flag and last-beat detection for one AXI burst.
// WRAP bursts are honoured only when IMG_FB_WRAP_BURST_EN is defined.
module img_fb_burst_addr
  import img_fb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int MEM_DEPTH_WORDS = 1024
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [7:0]        cnt,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              beat_err,
  output logic              last_beat
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_DEPTH_WORDS) << 2;

  logic              in_range;
  logic              burst_err;
  logic [ADDR_W-1:0] incr_addr;

  assign incr_addr = addr + ADDR_W'(4);
  assign in_range  = {1'b0, addr} < LIMIT;
  assign last_beat = (cnt == len);

`ifdef IMG_FB_WRAP_BURST_EN
  logic              wrap_len_ok;
  logic [ADDR_W-1:0] wrap_mask;

  // Legal wrap lengths are 2^k-1, so the byte mask is simply {len,2'b11}.
  assign wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  assign wrap_mask   = ADDR_W'({len[3:0], 2'b11});

  always_comb begin
    next_addr = incr_addr;
    burst_err = 1'b0;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
      BURST_WRAP: begin
        if (wrap_len_ok) next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        else             burst_err = 1'b1;
      end
      default:     burst_err = 1'b1;
    endcase
  end
`else
  always_comb begin
    next_addr = incr_addr;
    burst_err = 1'b0;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
      default:     burst_err = 1'b1;
    endcase
  end
`endif

  assign beat_err = !in_range || (size != SIZE_WORD) || burst_err;

endmodule

// File: rtl/image_frame_buffer_slave.sv
// AXI4 slave frame buffer: one burst at a time serialised onto a single-port word memory.
// Optional WRAP burst support is enabled by defining IMG_FB_WRAP_BURST_EN.
module image_frame_buffer_slave
  import img_fb_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH_WORDS    = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output fsm_state_e                      dbg_state
);

  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int IW    = C_S_AXI_ID_WIDTH;
  localparam int IDX_W = idx_width(MEM_DEPTH_WORDS);

  // Handshakes: a transfer happens on any rising ACLK where VALID and READY are both
  // high; VALID never waits on READY, and once raised VALID/payload hold until the transfer.

  fsm_state_e state_q, state_d;

  logic          aw_rdy_q, ar_rdy_q, prefer_w_q;
  logic [AW-1:0] cur_addr_q;
  logic [7:0]    cur_len_q, cur_cnt_q;
  logic [2:0]    cur_size_q;
  logic [1:0]    cur_burst_q;

  logic          err_q, bvalid_q;
  logic [1:0]    bresp_q;
  logic [IW-1:0] bid_q, rid_q;

  logic          issue_done_q, pend_q, pend_err_q, pend_last_q;
  logic          rvalid_q, rlast_q;
  logic [1:0]    rresp_q;
  logic [DW-1:0] rdata_q, rd_q;

  logic [DW-1:0] mem [MEM_DEPTH_WORDS];

  logic [AW-1:0]    next_addr;
  logic             beat_err, last_beat;
  logic             aw_hs, ar_hs, w_hs, w_final, w_len_err;
  logic             advance, r_hs, rd_issue, mem_we, mem_re;
  logic [IDX_W-1:0] mem_idx;

  img_fb_burst_addr #(
    .ADDR_W          (AW),
    .MEM_DEPTH_WORDS (MEM_DEPTH_WORDS)
  ) u_burst_addr (
    .addr      (cur_addr_q),
    .len       (cur_len_q),
    .cnt       (cur_cnt_q),
    .size      (cur_size_q),
    .burst     (cur_burst_q),
    .next_addr (next_addr),
    .beat_err  (beat_err),
    .last_beat (last_beat)
  );

  assign aw_hs     = aw_rdy_q && S_AXI_AWVALID;
  assign ar_hs     = ar_rdy_q && S_AXI_ARVALID;
  assign w_hs      = (state_q == ST_WR_DATA) && S_AXI_WVALID;
  assign w_final   = S_AXI_WLAST || last_beat;
  assign w_len_err = S_AXI_WLAST ^ last_beat;

  // Read pipeline: memory fetch stage (pend) feeding the R output register.
  // A fetch is issued whenever the pending slot is empty or drains this cycle.
  assign advance  = !rvalid_q || S_AXI_RREADY;
  assign r_hs     = rvalid_q && S_AXI_RREADY;
  assign rd_issue = (state_q == ST_RD_DATA) && !issue_done_q && (!pend_q || advance);

  assign mem_we  = w_hs && !beat_err;
  assign mem_re  = rd_issue && !beat_err;
  assign mem_idx = cur_addr_q[2 +: IDX_W];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (aw_hs)      state_d = ST_WR_DATA;
        else if (ar_hs) state_d = ST_RD_DATA;
      end
      ST_WR_DATA: if (w_hs && w_final)               state_d = ST_WR_RESP;
      ST_WR_RESP: if (bvalid_q && S_AXI_BREADY)      state_d = ST_IDLE;
      ST_RD_DATA: if (r_hs && rlast_q)               state_d = ST_IDLE;
      default:                                       state_d = ST_IDLE;
    endcase
  end

  // FSM, arbitration and the burst context shared by both directions.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= ST_IDLE;
      aw_rdy_q    <= 1'b0;
      ar_rdy_q    <= 1'b0;
      prefer_w_q  <= 1'b1;
      cur_addr_q  <= '0;
      cur_len_q   <= '0;
      cur_cnt_q   <= '0;
      cur_size_q  <= '0;
      cur_burst_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && !aw_rdy_q && !ar_rdy_q) begin
        if (S_AXI_AWVALID && (!S_AXI_ARVALID || prefer_w_q)) begin
          aw_rdy_q   <= 1'b1;
          prefer_w_q <= 1'b0;
        end else if (S_AXI_ARVALID) begin
          ar_rdy_q   <= 1'b1;
          prefer_w_q <= 1'b1;
        end
      end else begin
        aw_rdy_q <= 1'b0;
        ar_rdy_q <= 1'b0;
      end

      if (aw_hs) begin
        cur_addr_q  <= S_AXI_AWADDR;
        cur_len_q   <= S_AXI_AWLEN;
        cur_size_q  <= S_AXI_AWSIZE;
        cur_burst_q <= S_AXI_AWBURST;
        cur_cnt_q   <= '0;
      end else if (ar_hs) begin
        cur_addr_q  <= S_AXI_ARADDR;
        cur_len_q   <= S_AXI_ARLEN;
        cur_size_q  <= S_AXI_ARSIZE;
        cur_burst_q <= S_AXI_ARBURST;
        cur_cnt_q   <= '0;
      end else if (w_hs || rd_issue) begin
        cur_addr_q <= next_addr;
        cur_cnt_q  <= cur_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      err_q    <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      bid_q    <= '0;
    end else begin
      if (aw_hs) begin
        err_q <= 1'b0;
        bid_q <= S_AXI_AWID;
      end
      if (w_hs) begin
        err_q <= err_q | beat_err;
        if (w_final) begin
          bvalid_q <= 1'b1;
          bresp_q  <= (err_q || beat_err || w_len_err) ? RESP_SLVERR : RESP_OKAY;
        end
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rid_q        <= '0;
      issue_done_q <= 1'b0;
      pend_q       <= 1'b0;
      pend_err_q   <= 1'b0;
      pend_last_q  <= 1'b0;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
    end else begin
      if (ar_hs) begin
        rid_q        <= S_AXI_ARID;
        issue_done_q <= 1'b0;
      end
      if (advance) begin
        rvalid_q <= pend_q;
        rlast_q  <= pend_q && pend_last_q;
        if (pend_q) begin
          rdata_q <= pend_err_q ? '0 : rd_q;
          rresp_q <= pend_err_q ? RESP_SLVERR : RESP_OKAY;
        end
      end
      if (rd_issue) begin
        pend_q      <= 1'b1;
        pend_err_q  <= beat_err;
        pend_last_q <= last_beat;
        if (last_beat) issue_done_q <= 1'b1;
      end else if (advance) begin
        pend_q <= 1'b0;
      end
    end
  end

  // Frame buffer storage is deliberately left unreset.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (S_AXI_WSTRB[b]) mem[mem_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
    if (mem_re) rd_q <= mem[mem_idx];
  end

  assign S_AXI_AWREADY = aw_rdy_q;
  assign S_AXI_ARREADY = ar_rdy_q;
  assign S_AXI_WREADY  = (state_q == ST_WR_DATA);
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BID     = bid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RID     = rid_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_image_frame_buffer_slave.sv
// Directed self-checking bench for image_frame_buffer_slave (MEM_DEPTH_WORDS = 1024).
module tb_image_frame_buffer_slave;
  import img_fb_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [0:0]  AWID = '0, BID, ARID = '0, RID;
  logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0, RDATA;
  logic [7:0]  AWLEN = '0, ARLEN = '0;
  logic [2:0]  AWSIZE = 3'b010, ARSIZE = 3'b010;
  logic [1:0]  AWBURST = 2'b01, ARBURST = 2'b01, BRESP, RRESP;
  logic [3:0]  WSTRB = '0;
  logic        AWVALID = 0, AWREADY, WLAST = 0, WVALID = 0, WREADY, BVALID, BREADY = 0;
  logic        ARVALID = 0, ARREADY, RLAST, RVALID, RREADY = 0;
  fsm_state_e  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [1:0]  b_resp;
  logic [0:0]  b_id, r_id;
  int          b_wait;
  logic [31:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];
  int          rd_n, rd_lat;

  always #5 ACLK = ~ACLK;

  image_frame_buffer_slave dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWID(AWID), .S_AXI_AWADDR(AWADDR), .S_AXI_AWLEN(AWLEN), .S_AXI_AWSIZE(AWSIZE),
    .S_AXI_AWBURST(AWBURST), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WLAST(WLAST), .S_AXI_WVALID(WVALID),
    .S_AXI_WREADY(WREADY), .S_AXI_BID(BID), .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID),
    .S_AXI_BREADY(BREADY), .S_AXI_ARID(ARID), .S_AXI_ARADDR(ARADDR), .S_AXI_ARLEN(ARLEN),
    .S_AXI_ARSIZE(ARSIZE), .S_AXI_ARBURST(ARBURST), .S_AXI_ARVALID(ARVALID),
    .S_AXI_ARREADY(ARREADY), .S_AXI_RID(RID), .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP),
    .S_AXI_RLAST(RLAST), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY), .dbg_state(dbg_state)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Driver: full write burst of nbeats beats, WLAST on the final driven beat.
  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input int nbeats, input logic [0:0] id);
    int t;
    AWADDR = addr; AWLEN = len; AWSIZE = 3'b010; AWBURST = burst; AWID = id; AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < 50) begin tick(); t++; end
    if (!AWREADY) begin
      checks++; errors++; $display("FAIL aw_timeout: AWREADY=0 required 1");
      AWVALID = 1'b0; b_resp = 2'bxx; return;
    end
    tick();
    AWVALID = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == nbeats - 1); WVALID = 1'b1;
      t = 0;
      while (!WREADY && t < 50) begin tick(); t++; end
      if (!WREADY) begin
        checks++; errors++; $display("FAIL w_timeout: WREADY=0 required 1 beat %0d", i);
        WVALID = 1'b0; WLAST = 1'b0; b_resp = 2'bxx; return;
      end
      tick();
    end
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    b_wait = 0;
    while (!BVALID && b_wait < 50) begin tick(); b_wait++; end
    if (!BVALID) begin
      checks++; errors++; $display("FAIL b_timeout: BVALID=0 required 1");
      BREADY = 1'b0; b_resp = 2'bxx; return;
    end
    b_resp = BRESP; b_id = BID;
    tick();
    BREADY = 1'b0;
  endtask

  // Driver: full read burst with RREADY held high, recording every beat.
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [0:0] id);
    int  t;
    logic done;
    ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARID = id; ARVALID = 1'b1;
    rd_n = 0; rd_lat = -1;
    t = 0;
    while (!ARREADY && t < 50) begin tick(); t++; end
    if (!ARREADY) begin
      checks++; errors++; $display("FAIL ar_timeout: ARREADY=0 required 1");
      ARVALID = 1'b0; return;
    end
    tick();
    ARVALID = 1'b0; RREADY = 1'b1;
    t = 0; done = 1'b0;
    while (!done && t < 600) begin
      if (rd_lat < 0 && RVALID) rd_lat = t;
      if (RVALID && rd_n < 256) begin
        rd_data[rd_n] = RDATA; rd_resp[rd_n] = RRESP; rd_last[rd_n] = RLAST; r_id = RID;
        rd_n++; done = RLAST;
      end
      tick(); t++;
    end
    RREADY = 1'b0;
    if (!done) begin checks++; errors++; $display("FAIL r_timeout: RLAST not seen after %0d beats", rd_n); end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (3) tick();
    if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b required 000000", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST});
    end
    checks++;
    if ({BRESP, RRESP, RDATA, BID, RID} !== 38'h0) begin
      errors++; $display("FAIL reset_fields: BRESP=%0h RRESP=%0h RDATA=%h BID=%0h RID=%0h required 0", BRESP, RRESP, RDATA, BID, RID);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE); end
    checks++;
    ARESETN = 1'b1;
    tick(); tick();
    if ({AWREADY, ARREADY, BVALID, RVALID} !== 4'b0) begin
      errors++; $display("FAIL idle_quiet: got %b required 0000", {AWREADY, ARREADY, BVALID, RVALID});
    end
    checks++;
  endtask

  task automatic test_arbitration();
    int t;
    AWADDR = 32'h40; AWLEN = 8'd0; AWSIZE = 3'b010; AWBURST = 2'b01; AWID = 1'b0; AWVALID = 1'b1;
    ARADDR = 32'h40; ARLEN = 8'd0; ARSIZE = 3'b010; ARBURST = 2'b01; ARID = 1'b1; ARVALID = 1'b1;
    t = 0;
    while (!AWREADY && !ARREADY && t < 50) begin tick(); t++; end
    if ({AWREADY, ARREADY} !== 2'b10) begin errors++; $display("FAIL arb_first: AWREADY,ARREADY=%b required 10", {AWREADY, ARREADY}); end
    checks++;
    tick();
    AWVALID = 1'b0;
    WDATA = 32'h5A5A1234; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
    t = 0;
    while (!WREADY && t < 20) begin tick(); t++; end
    tick();
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    t = 0;
    while (!BVALID && t < 20) begin tick(); t++; end
    if (BVALID !== 1'b1 || BRESP !== RESP_OKAY) begin errors++; $display("FAIL arb_bresp: BVALID=%b BRESP=%0h required 1/0", BVALID, BRESP); end
    checks++;
    tick();
    BREADY = 1'b0;
    t = 0;
    while (!ARREADY && t < 20) begin tick(); t++; end
    if (ARREADY !== 1'b1) begin errors++; $display("FAIL arb_second: ARREADY=%b required 1", ARREADY); end
    checks++;
    tick();
    ARVALID = 1'b0; RREADY = 1'b1;
    t = 0;
    while (!RVALID && t < 20) begin tick(); t++; end
    if (RDATA !== 32'h5A5A1234 || RLAST !== 1'b1 || RID !== 1'b1) begin
      errors++; $display("FAIL arb_rdata: RDATA=%h RLAST=%b RID=%0h required 5a5a1234/1/1", RDATA, RLAST, RID);
    end
    checks++;
    tick();
    RREADY = 1'b0;
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
    axi_write(32'h10, 8'd3, 2'b01, 4, 1'b1);
    if (b_resp !== RESP_OKAY || b_id !== 1'b1) begin errors++; $display("FAIL incr_bresp: BRESP=%0h BID=%0h required 0/1", b_resp, b_id); end
    checks++;
    if (b_wait !== 0) begin errors++; $display("FAIL incr_b_latency: BVALID after %0d extra cycles required 0", b_wait); end
    checks++;
    axi_read(32'h10, 8'd3, 2'b01, 3'b010, 1'b1);
    if (rd_lat !== 2) begin errors++; $display("FAIL incr_r_latency: got %0d required 2", rd_lat); end
    checks++;
    if (rd_n !== 4 || r_id !== 1'b1) begin errors++; $display("FAIL incr_r_count: beats=%0d RID=%0h required 4/1", rd_n, r_id); end
    checks++;
    for (int i = 0; i < 4; i++) begin
      if (rd_data[i] !== 32'hA0 + 32'(i) || rd_resp[i] !== RESP_OKAY || rd_last[i] !== (i == 3)) begin
        errors++; $display("FAIL incr_beat%0d: data=%h resp=%0h last=%b required %h/0/%b", i, rd_data[i], rd_resp[i], rd_last[i], 32'hA0 + 32'(i), i == 3);
      end
      checks++;
    end
  endtask

  task automatic test_strobe();
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    axi_write(32'h0, 8'd0, 2'b01, 1, 1'b0);
    wd[0] = 32'h11223344; ws[0] = 4'b0101;
    axi_write(32'h0, 8'd0, 2'b01, 1, 1'b0);
    axi_read(32'h0, 8'd0, 2'b01, 3'b010, 1'b0);
    if (rd_data[0] !== 32'hFF22FF44 || rd_resp[0] !== RESP_OKAY) begin
      errors++; $display("FAIL strobe_merge: got %h/%0h required ff22ff44/0", rd_data[0], rd_resp[0]);
    end
    checks++;
  endtask

  task automatic test_top_boundary();
    logic [31:0] exp_d [4];
    logic [1:0]  exp_r [4];
    exp_d = '{32'hB0, 32'hB1, 32'h0, 32'h0};
    exp_r = '{RESP_OKAY, RESP_OKAY, RESP_SLVERR, RESP_SLVERR};
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0 + 32'(i); ws[i] = 4'hF; end
    axi_write(32'hFF8, 8'd3, 2'b01, 4, 1'b0);
    if (b_resp !== RESP_SLVERR) begin errors++; $display("FAIL top_bresp: got %0h required 2", b_resp); end
    checks++;
    axi_read(32'hFF8, 8'd3, 2'b01, 3'b010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (rd_data[i] !== exp_d[i] || rd_resp[i] !== exp_r[i]) begin
        errors++; $display("FAIL top_beat%0d: data=%h resp=%0h required %h/%0h", i, rd_data[i], rd_resp[i], exp_d[i], exp_r[i]);
      end
      checks++;
    end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hD0 + 32'(i); ws[i] = 4'hF; end
    axi_write(32'h80, 8'd3, 2'b01, 2, 1'b0);
    if (b_resp !== RESP_SLVERR) begin errors++; $display("FAIL early_wlast: BRESP=%0h required 2", b_resp); end
    checks++;
    axi_read(32'h10, 8'd0, 2'b01, 3'b001, 1'b0);
    if (rd_data[0] !== 32'h0 || rd_resp[0] !== RESP_SLVERR) begin
      errors++; $display("FAIL bad_size: data=%h resp=%0h required 0/2", rd_data[0], rd_resp[0]);
    end
    checks++;
  endtask

  task automatic test_backpressure();
    int t;
    ARADDR = 32'h10; ARLEN = 8'd1; ARSIZE = 3'b010; ARBURST = 2'b01; ARID = 1'b0; ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < 20) begin tick(); t++; end
    tick();
    ARVALID = 1'b0;
    t = 0;
    while (!RVALID && t < 20) begin tick(); t++; end
    repeat (3) tick();
    if (RVALID !== 1'b1 || RDATA !== 32'hA0 || RLAST !== 1'b0) begin
      errors++; $display("FAIL stall_hold: RVALID=%b RDATA=%h RLAST=%b required 1/a0/0", RVALID, RDATA, RLAST);
    end
    checks++;
    RREADY = 1'b1;
    tick();
    if (RVALID !== 1'b1 || RDATA !== 32'hA1 || RLAST !== 1'b1) begin
      errors++; $display("FAIL stall_next: RVALID=%b RDATA=%h RLAST=%b required 1/a1/1", RVALID, RDATA, RLAST);
    end
    checks++;
    tick();
    RREADY = 1'b0;
    if (RVALID !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL stall_end: RVALID=%b state=%0d required 0/0", RVALID, dbg_state); end
    checks++;
  endtask

  task automatic test_reset_mid_burst();
    int t, n;
    ARADDR = 32'h10; ARLEN = 8'd7; ARSIZE = 3'b010; ARBURST = 2'b01; ARID = 1'b1; ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < 20) begin tick(); t++; end
    tick();
    ARVALID = 1'b0; RREADY = 1'b1;
    t = 0; n = 0;
    while (t < 50) begin
      if (RVALID) begin
        if (n == 2) break;
        n++;
      end
      tick(); t++;
    end
    if (RVALID !== 1'b1 || RDATA !== 32'hA2) begin errors++; $display("FAIL midrst_beat2: RVALID=%b RDATA=%h required 1/a2", RVALID, RDATA); end
    checks++;
    ARESETN = 1'b0;
    #1;
    if (RVALID !== 1'b0 || RLAST !== 1'b0 || RDATA !== 32'h0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL midrst_clear: RVALID=%b RLAST=%b RDATA=%h state=%0d required 0/0/0/0", RVALID, RLAST, RDATA, dbg_state);
    end
    checks++;
    RREADY = 1'b0;
    tick(); tick();
    ARESETN = 1'b1;
    tick();
    axi_read(32'h10, 8'd3, 2'b01, 3'b010, 1'b0);
    if (rd_n !== 4 || rd_data[0] !== 32'hA0 || rd_data[3] !== 32'hA3 || rd_resp[3] !== RESP_OKAY || rd_last[3] !== 1'b1) begin
      errors++; $display("FAIL midrst_after: beats=%0d d0=%h d3=%h resp3=%0h required 4/a0/a3/0", rd_n, rd_data[0], rd_data[3], rd_resp[3]);
    end
    checks++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_d [4];
    logic [1:0]  exp_b;
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0 + 32'(i); ws[i] = 4'hF; end
`ifdef IMG_FB_WRAP_BURST_EN
    exp_b = RESP_OKAY;
    exp_d = '{32'hC1, 32'hC2, 32'hC3, 32'hC0};
`else
    exp_b = RESP_SLVERR;
    exp_d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
`endif
    axi_write(32'h1C, 8'd3, 2'b10, 4, 1'b0);
    if (b_resp !== exp_b) begin errors++; $display("FAIL wrap_bresp: got %0h required %0h", b_resp, exp_b); end
    checks++;
    axi_read(32'h10, 8'd3, 2'b01, 3'b010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (rd_data[i] !== exp_d[i]) begin errors++; $display("FAIL wrap_mem%0d: got %h required %h", i, rd_data[i], exp_d[i]); end
      checks++;
    end
    axi_read(32'h1C, 8'd3, 2'b10, 3'b010, 1'b0);
`ifdef IMG_FB_WRAP_BURST_EN
    if (rd_data[1] !== 32'hC1 || rd_resp[1] !== RESP_OKAY) begin errors++; $display("FAIL wrap_read: got %h/%0h required c1/0", rd_data[1], rd_resp[1]); end
`else
    if (rd_data[1] !== 32'h0 || rd_resp[1] !== RESP_SLVERR) begin errors++; $display("FAIL wrap_read: got %h/%0h required 0/2", rd_data[1], rd_resp[1]); end
`endif
    checks++;
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_incr();
    test_strobe();
    test_top_boundary();
    test_errors();
    test_backpressure();
    test_reset_mid_burst();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
